// File: rtl/dp_accum.sv
// dp_accum: groups K_STEPS signed partial sums into one result and buffers results in a FIFO.
// Optional saturating adds and sticky sat_flag with macro DP_ACCUM_SAT_EN.
module dp_accum #(
    parameter int DW_ADD     = 32,
    parameter int DW_ACC     = 32,
    parameter int K_STEPS    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DW_ADD-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DW_ACC-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              sat_flag
);
    localparam int CW = K_STEPS > 1 ? $clog2(K_STEPS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic signed [DW_ACC-1:0] acc_q, acc_d, ext, base, res;
    logic [DW_ACC-1:0]        mem_q [FIFO_DEPTH];
    logic [DW_ACC-1:0]        mem_d [FIFO_DEPTH];
    logic [AW:0]              wp_q, wp_d, rp_q, rp_d;
    logic                     sat_q, sat_d;
    logic                     last, full, empty, accept, push, pop, ovf;
`ifdef DP_ACCUM_SAT_EN
    logic signed [DW_ACC:0]   wide;
`endif

    always_comb begin
        ext = DW_ACC'($signed(in_data));
        // the first beat of a group starts from zero so a stale acc never leaks in
        base = (cnt_q == '0) ? '0 : acc_q;
`ifdef DP_ACCUM_SAT_EN
        wide = {base[DW_ACC-1], base} + {ext[DW_ACC-1], ext};
        ovf = wide[DW_ACC] != wide[DW_ACC-1];
        res = !ovf ? wide[DW_ACC-1:0] :
              wide[DW_ACC] ? {1'b1, {(DW_ACC-1){1'b0}}} : {1'b0, {(DW_ACC-1){1'b1}}};
`else
        ovf = 1'b0;
        res = base + ext;
`endif
        last = cnt_q == CW'(K_STEPS - 1);
        full = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
        empty = wp_q == rp_q;
        // stall only the group-closing beat; a same-cycle pop does not release it
        in_ready = !(last && full);
        accept = enable && in_valid && in_ready;
        push = accept && last;
        pop = !empty && out_ready;
        cnt_d = accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        acc_d = accept ? res : acc_q;
        sat_d = sat_q || (accept && ovf);
        wp_d = wp_q + (AW + 1)'(push);
        rp_d = rp_q + (AW + 1)'(pop);
        mem_d = mem_q;
        if (push) mem_d[wp_q[AW-1:0]] = res;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            acc_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            sat_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            sat_q <= sat_d;
            mem_q <= mem_d;
        end
    end

    assign out_valid = !empty;
    assign out_data  = mem_q[rp_q[AW-1:0]];
    assign busy      = cnt_q != '0;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_dp_accum.sv
// tb_dp_accum: directed checks of dp_accum with default parameters.
module tb_dp_accum;
    logic        clk = 1'b0;
    logic        reset, enable, in_valid, in_ready, out_valid, out_ready, busy, sat_flag;
    logic [31:0] in_data, out_data;
    int          n_chk = 0, n_fail = 0;

    dp_accum dut (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        enable = 1'b1;
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sat", sat_flag, 0);
        reset = 1'b1;
        tick();
        out_ready = 1'b1;
        beat(1); beat(2); beat(3);
        chk("basic_busy", busy, 1);
        chk("basic_no_early_valid", out_valid, 0);
        beat(4);
        chk("basic_valid", out_valid, 1);
        chk("basic_data", out_data, 10);
        chk("basic_idle", busy, 0);
        tick();
        chk("basic_popped", out_valid, 0);
        beat(-5); beat(3); beat(-7); beat(1);
        chk("signed_valid", out_valid, 1);
        chk("signed_data", out_data, 32'hFFFF_FFF8);
        tick();
        chk("signed_popped", out_valid, 0);
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            beat(1); beat(1); beat(1); beat(1);
        end
        beat(1); beat(1); beat(1);
        chk("bp_stall", in_ready, 0);
        chk("bp_head_valid", out_valid, 1);
        chk("bp_head_data", out_data, 4);
        in_valid = 1'b1; in_data = 1; out_ready = 1'b1;
        tick();
        chk("bp_pop_no_accept", busy, 1);
        chk("bp_ready_after_pop", in_ready, 1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("bp_fifth_accepted", busy, 0);
        chk("bp_full_again", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_data", out_data, 4);
            tick();
        end
        chk("bp_drained", out_valid, 0);
        beat(32'h7FFF_FFF0); beat(32'h20); beat(0); beat(0);
        chk("sat_valid", out_valid, 1);
`ifdef DP_ACCUM_SAT_EN
        chk("sat_data", out_data, 32'h7FFF_FFFF);
        chk("sat_flag", sat_flag, 1);
`else
        chk("sat_data", out_data, 32'h8000_0010);
        chk("sat_flag", sat_flag, 0);
`endif
        tick();
        beat(9); beat(9);
        chk("mid_busy", busy, 1);
        reset = 1'b0;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_sat", sat_flag, 0);
        reset = 1'b1;
        beat(1); beat(1); beat(1);
        chk("mid_no_result", out_valid, 0);
        beat(1);
        chk("mid_valid", out_valid, 1);
        chk("mid_data", out_data, 4);
        tick();
        chk("mid_single", out_valid, 0);
        beat(1); beat(2);
        enable = 1'b0; in_valid = 1'b1; in_data = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_gap_busy", busy, 1);
            chk("en_gap_no_out", out_valid, 0);
        end
        beat(3); beat(4);
        chk("en_valid", out_valid, 1);
        chk("en_data", out_data, 10);
        tick();
        chk("en_popped", out_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_accum.md
DP_ACCUM -- requirements
Module: dp_accum

Interface
REQ-001 SHALL have parameter DW_ADD, default 32, width of each incoming dot-product partial sum.
REQ-002 SHALL have parameter DW_ACC, default 32, width of accumulated result (DW_ACC >= DW_ADD).
REQ-003 SHALL have parameter K_STEPS, default 4, partial sums per result (>= 1).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (power of 2, >= 2).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  input  1  gates input acceptance only.
REQ-008 SHALL have port in_data  input  DW_ADD  signed partial sum from upstream dot-product stage.
REQ-009 SHALL have port in_valid  input  1  in_data qualifier.
REQ-010 SHALL have port in_ready  output  1  beat accepted when enable & in_valid & in_ready at clk edge.
REQ-011 SHALL have port out_data  output  DW_ACC  signed result at FIFO head.
REQ-012 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port out_ready  input  1  pop when out_valid & out_ready at clk edge.
REQ-014 SHALL have port busy  output  1  high while beat counter is non-zero.
REQ-015 SHALL have port sat_flag  output  1  sticky saturation indicator.

Function
REQ-016 SHALL keep beat counter cnt in 0..K_STEPS-1; states IDLE (cnt=0) and ACC (cnt>0).
REQ-017 SHALL, on an accepted beat in IDLE, load acc = sign-extended in_data, discarding any stale value.
REQ-018 SHALL, on an accepted beat in ACC, set acc = acc + sign-extended in_data.
REQ-019 SHALL, on the K_STEPS-th accepted beat, push acc + in_data (in_data alone if K_STEPS=1) into FIFO and return cnt to 0 on that edge.
REQ-020 SHALL assert out_valid on the cycle after the final beat is accepted when FIFO was empty (1-cycle latency).
REQ-021 SHALL drive in_ready = 1 except when cnt = K_STEPS-1 and FIFO full.
REQ-022 SHALL derive in_ready without out_ready; a simultaneous pop does not release a full-FIFO stall that cycle.
REQ-023 SHALL, when enable low, accept no beats and hold cnt and acc; the output side keeps operating.
REQ-024 SHALL keep out_data stable while out_valid & !out_ready.
REQ-025 SHALL support simultaneous push and pop when not full; occupancy unchanged.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; results emitted in push order.

Reset
REQ-027 SHALL, while reset low, clear cnt, acc, FIFO pointers and contents, and sat_flag, giving out_valid=0, out_data=0, busy=0, in_ready=1.
REQ-028 SHALL discard a partially accumulated group and all buffered results on reset assertion mid-operation.

Configuration
REQ-029 SHALL, with macro DP_ACCUM_SAT_EN defined, clamp every add in REQ-018/019 to the signed DW_ACC range and set sat_flag on any clamp, cleared only by reset.
REQ-030 SHALL, without DP_ACCUM_SAT_EN, wrap adds in two's complement and tie sat_flag to 0.

Verification
REQ-031 SHALL cover basic accumulation: K_STEPS=4, beats 1,2,3,4 back-to-back, out_ready=1 -> out_data=10, out_valid one cycle after 4th beat.
REQ-032 SHALL cover signed data: beats -5,3,-7,1 -> out_data=-8 (0xFFFFFFF8).
REQ-033 SHALL cover backpressure: out_ready=0, five groups of 1,1,1,1 -> four results of 4 buffered, in_ready=0 at 4th beat of 5th group; one pop -> 5th accepted next cycle, five 4s emitted in order.
REQ-034 SHALL cover saturation: beats 0x7FFFFFF0,0x20,0,0 -> with DP_ACCUM_SAT_EN out_data=0x7FFFFFFF, sat_flag=1; without, out_data=0x80000010, sat_flag=0.
REQ-035 SHALL cover reset mid-group: beats 9,9 then reset pulse, then 1,1,1,1 -> single result 4, no result containing 9.
REQ-036 SHALL cover enable gating: enable=0 for 3 cycles between beats 2 and 3 of 1,2,3,4 with in_valid=1 -> out_data=10, busy held high throughout the gap.
